ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the RVX10 five-stage pipeline.
- Holds the ID/EX register and resolves operand forwarding from MEM and WB.
- Drives the existing 5-bit-opcode ALU, resolves BEQ/JAL redirects, and registers results into the EX/MEM register.
- Sits between the decode stage / hazard unit upstream and the data-memory stage downstream.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; the ALU is fixed-width.
- PC_RESET, 32'h0000_0000, reset value of the registered pc fields.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- valid_d  in  1  decode slot holds a real instruction
- rd1_d, rd2_d  in  32  register-file read data
- pc_d, pcplus4_d, immext_d  in  32  pc, pc+4, sign-extended immediate
- rs1_d, rs2_d, rd_d  in  5  register indices
- alucontrol_d  in  5  ALU opcode (rvx10_pkg::alu_op_t)
- alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d  in  1  decoded controls
- resultsrc_d  in  2  00 ALU, 01 memory, 10 pc+4
- stall_e  in  1  hold ID/EX contents
- flush_e  in  1  load a bubble into ID/EX
- result_w  in  32  WB-stage write-back value
- regwrite_w  in  1  WB-stage write enable
- rd_w  in  5  WB-stage destination
- rs1_e, rs2_e, rd_e  out  5  to hazard unit
- resultsrc0_e  out  1  load-in-E flag for the hazard unit
- pcsrc_e  out  1  redirect fetch this cycle
- pctarget_e  out  32  pc_e + immext_e
- valid_m, regwrite_m, memwrite_m  out  1  EX/MEM controls
- resultsrc_m  out  2  EX/MEM result select
- aluresult_m, writedata_m, pcplus4_m  out  32  EX/MEM data
- rd_m  out  5  EX/MEM destination

Behaviour:
- Reset (reset=0, async): all ID/EX and EX/MEM fields clear to 0, pc fields to PC_RESET, valid bits to 0. Consequently all outputs are 0 and pcsrc_e=0.
- ID/EX update each rising edge, in priority order:
  - flush_e: load a bubble (valid=0, all controls=0, data fields don't-care but driven 0).
  - else stall_e: hold all fields.
  - else: capture the *_d inputs.
  - flush_e takes priority over stall_e when both are asserted.
- Forwarding, combinational, per source. Shown for A; B is identical using rs2_e.
  - fwdA=FWD_MEM when valid_m & regwrite_m & rd_m!=0 & rd_m==rs1_e.
  - else fwdA=FWD_WB when regwrite_w & rd_w!=0 & rd_w==rs1_e.
  - else FWD_REG.
  - MEM beats WB when both match.
  - x0 never forwards.
- Operand selection:
  - srcA = forwarded rs1 value.
  - writedata_e = forwarded rs2 value.
  - srcB = alusrc_e ? immext_e : writedata_e.
- ALU: result and zero are combinational from the instantiated alu; the full alucontrol_e[4:0] passes unmodified.
- pctarget_e = pc_e + immext_e, modulo 2^32.
- pcsrc_e = valid_e & ~stall_e & (jump_e | (branch_e & zero)).
  - Asserted for exactly one cycle per redirecting instruction.
  - Upstream is responsible for asserting flush_e on the following edge.
- EX/MEM advances every edge and never stalls.
  - If valid_e & ~stall_e: capture regwrite, memwrite, resultsrc, aluresult, writedata, rd, pcplus4, and set valid_m=1.
  - Otherwise: bubble (valid_m=0, regwrite_m=0, memwrite_m=0). A stalled E instruction is therefore never issued to MEM twice.
- Latency: an instruction captured on edge N appears at the EX/MEM outputs after edge N+1, absent stall.
- A reset deasserted mid-operation restarts with an empty pipe. No partial state survives.

Decomposition:
- rvx10_pkg holds:
  - alu_op_t enum covering ADD=00000 through ABS=10001, matching the ALU encodings.
  - fwd_sel_t enum: FWD_REG=00, FWD_WB=01, FWD_MEM=10.
  - resultsrc constants.
  - packed structs ex_ctrl_t (valid, regwrite, memwrite, resultsrc, branch, jump, alusrc, alucontrol) and mem_ctrl_t.
- Exactly one sub-module: the existing alu, instantiated unchanged. Forwarding and pipeline registers stay inline.

Test Plan:
- Reset: hold reset=0 with random *_d inputs → all outputs 0. Release reset, then capture ADD rd1=5, rd2=7, rd=3 → after 2 edges aluresult_m=12, rd_m=3, regwrite_m=1, valid_m=1.
- MEM forward: ADD x1=3+4, followed by SUB x2=x1−1 with rd1_d stale 0 → SUB aluresult_m=6, fwdA=FWD_MEM. With rd=0 on the first instruction instead, no forwarding occurs and the result is −1.
- WB priority: rd_m=5 (aluresult 9) and rd_w=5 (result_w 100) both match rs1_e=5, with an XOR against 0 → aluresult_m=9.
- Branch: BEQ with pc=0x100, imm=0x20, equal operands → pcsrc_e=1 for one cycle, pctarget_e=0x120. With unequal operands, pcsrc_e=0.
- Stall/flush: stall_e held 2 cycles on MAXU(3, 0xFFFF_FFFF) → 2 bubbles at MEM, then one valid_m with aluresult_m=0xFFFF_FFFF. flush_e and stall_e together → bubble loaded.
- Custom op: ROL a=0x8000_0001, srcB from imm=1 (alusrc=1) → aluresult_m=0x0000_0003. Assert reset mid-stream → valid_m falls to 0 immediately.

Source files
------------

// File: rtl/rvx10_pkg.sv
// Shared types for the RVX10 pipeline: ALU opcodes, forwarding selects and
// the control bundles carried in the ID/EX and EX/MEM registers.
package rvx10_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b00001,
        ALU_AND  = 5'b00010,
        ALU_OR   = 5'b00011,
        ALU_XOR  = 5'b00100,
        ALU_SLT  = 5'b00101,
        ALU_SLL  = 5'b00110,
        ALU_SRL  = 5'b00111,
        ALU_ANDN = 5'b01000,
        ALU_ORN  = 5'b01001,
        ALU_XNOR = 5'b01010,
        ALU_MIN  = 5'b01011,
        ALU_MAX  = 5'b01100,
        ALU_MINU = 5'b01101,
        ALU_MAXU = 5'b01110,
        ALU_ROL  = 5'b01111,
        ALU_ROR  = 5'b10000,
        ALU_ABS  = 5'b10001
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic [1:0] resultsrc;
        logic       branch;
        logic       jump;
        logic       alusrc;
        alu_op_t    alucontrol;
    } ex_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memwrite;
        logic [1:0] resultsrc;
    } mem_ctrl_t;

    // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
    function automatic fwd_sel_t fwd_sel(
        input logic       valid_m,
        input logic       regwrite_m,
        input logic [4:0] rd_m,
        input logic       regwrite_w,
        input logic [4:0] rd_w,
        input logic [4:0] rs
    );
        if (valid_m && regwrite_m && (rd_m != 5'd0) && (rd_m == rs)) return FWD_MEM;
        if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs)) return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/alu.sv
// RVX10 32-bit ALU: base integer ops plus the custom logic/min-max/rotate/abs ops.
module alu
    import rvx10_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     alucontrol,
    output logic [31:0] result,
    output logic        zero
);

    logic [4:0]  shamt;
    logic        lt_s;
    logic        lt_u;
    logic [31:0] rol_v;
    logic [31:0] ror_v;

    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    assign rol_v = (shamt == 5'd0) ? a : ((a << shamt) | (a >> (6'd32 - {1'b0, shamt})));
    assign ror_v = (shamt == 5'd0) ? a : ((a >> shamt) | (a << (6'd32 - {1'b0, shamt})));

    always_comb begin
        result = '0;
        case (alucontrol)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {31'b0, lt_s};
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_ANDN: result = a & ~b;
            ALU_ORN:  result = a | ~b;
            ALU_XNOR: result = ~(a ^ b);
            ALU_MIN:  result = lt_s ? a : b;
            ALU_MAX:  result = lt_s ? b : a;
            ALU_MINU: result = lt_u ? a : b;
            ALU_MAXU: result = lt_u ? b : a;
            ALU_ROL:  result = rol_v;
            ALU_ROR:  result = ror_v;
            ALU_ABS:  result = a[31] ? (32'd0 - a) : a;
            default:  result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/ex_stage.sv
// RVX10 execute stage: ID/EX register, MEM/WB operand forwarding, ALU,
// BEQ/JAL redirect and the EX/MEM register.
module ex_stage
    import rvx10_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_d,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pcplus4_d,
    input  logic [XLEN-1:0] immext_d,
    input  logic [4:0]      rs1_d,
    input  logic [4:0]      rs2_d,
    input  logic [4:0]      rd_d,
    input  logic [4:0]      alucontrol_d,
    input  logic            alusrc_d,
    input  logic            regwrite_d,
    input  logic            memwrite_d,
    input  logic            branch_d,
    input  logic            jump_d,
    input  logic [1:0]      resultsrc_d,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic [XLEN-1:0] result_w,
    input  logic            regwrite_w,
    input  logic [4:0]      rd_w,
    output logic [4:0]      rs1_e,
    output logic [4:0]      rs2_e,
    output logic [4:0]      rd_e,
    output logic            resultsrc0_e,
    output logic            pcsrc_e,
    output logic [XLEN-1:0] pctarget_e,
    output logic            valid_m,
    output logic            regwrite_m,
    output logic            memwrite_m,
    output logic [1:0]      resultsrc_m,
    output logic [XLEN-1:0] aluresult_m,
    output logic [XLEN-1:0] writedata_m,
    output logic [XLEN-1:0] pcplus4_m,
    output logic [4:0]      rd_m
);

    ex_ctrl_t        ctrl_e;
    logic [XLEN-1:0] rd1_e, rd2_e, pc_e, pcplus4_e, immext_e;
    mem_ctrl_t       ctrl_m;

    fwd_sel_t        fwd_a, fwd_b;
    logic [XLEN-1:0] srca_e, srcb_e, writedata_e, aluresult_e;
    logic            zero_e;
    logic            issue_e;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_e    <= '0;
            rd1_e     <= '0;
            rd2_e     <= '0;
            pc_e      <= PC_RESET;
            pcplus4_e <= PC_RESET;
            immext_e  <= '0;
            rs1_e     <= '0;
            rs2_e     <= '0;
            rd_e      <= '0;
        end else if (flush_e) begin
            ctrl_e    <= '0;
            rd1_e     <= '0;
            rd2_e     <= '0;
            pc_e      <= '0;
            pcplus4_e <= '0;
            immext_e  <= '0;
            rs1_e     <= '0;
            rs2_e     <= '0;
            rd_e      <= '0;
        end else if (!stall_e) begin
            ctrl_e    <= '{valid:      valid_d,
                           regwrite:   regwrite_d,
                           memwrite:   memwrite_d,
                           resultsrc:  resultsrc_d,
                           branch:     branch_d,
                           jump:       jump_d,
                           alusrc:     alusrc_d,
                           alucontrol: alu_op_t'(alucontrol_d)};
            rd1_e     <= rd1_d;
            rd2_e     <= rd2_d;
            pc_e      <= pc_d;
            pcplus4_e <= pcplus4_d;
            immext_e  <= immext_d;
            rs1_e     <= rs1_d;
            rs2_e     <= rs2_d;
            rd_e      <= rd_d;
        end
    end

    always_comb begin
        fwd_a = fwd_sel(ctrl_m.valid, ctrl_m.regwrite, rd_m, regwrite_w, rd_w, rs1_e);
        fwd_b = fwd_sel(ctrl_m.valid, ctrl_m.regwrite, rd_m, regwrite_w, rd_w, rs2_e);
        case (fwd_a)
            FWD_MEM: srca_e = aluresult_m;
            FWD_WB:  srca_e = result_w;
            default: srca_e = rd1_e;
        endcase
        case (fwd_b)
            FWD_MEM: writedata_e = aluresult_m;
            FWD_WB:  writedata_e = result_w;
            default: writedata_e = rd2_e;
        endcase
    end

    assign srcb_e = ctrl_e.alusrc ? immext_e : writedata_e;

    alu u_alu (
        .a          (srca_e),
        .b          (srcb_e),
        .alucontrol (ctrl_e.alucontrol),
        .result     (aluresult_e),
        .zero       (zero_e)
    );

    // A stalled instruction neither redirects nor issues; it does both once released.
    assign issue_e      = ctrl_e.valid & ~stall_e;
    assign pcsrc_e      = issue_e & (ctrl_e.jump | (ctrl_e.branch & zero_e));
    assign pctarget_e   = pc_e + immext_e;
    assign resultsrc0_e = ctrl_e.resultsrc[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_m      <= '0;
            aluresult_m <= '0;
            writedata_m <= '0;
            pcplus4_m   <= PC_RESET;
            rd_m        <= '0;
        end else if (issue_e) begin
            ctrl_m      <= '{valid:     1'b1,
                             regwrite:  ctrl_e.regwrite,
                             memwrite:  ctrl_e.memwrite,
                             resultsrc: ctrl_e.resultsrc};
            aluresult_m <= aluresult_e;
            writedata_m <= writedata_e;
            pcplus4_m   <= pcplus4_e;
            rd_m        <= rd_e;
        end else begin
            ctrl_m      <= '0;
        end
    end

    assign valid_m     = ctrl_m.valid;
    assign regwrite_m  = ctrl_m.regwrite;
    assign memwrite_m  = ctrl_m.memwrite;
    assign resultsrc_m = ctrl_m.resultsrc;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: opcode table, hand-written hazard/redirect
// sequences, and a randomized instruction stream against an architectural model.
module tb_ex_stage;
    import rvx10_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_d;
    logic [31:0] rd1_d, rd2_d, pc_d, pcplus4_d, immext_d;
    logic [4:0]  rs1_d, rs2_d, rd_d, alucontrol_d;
    logic        alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d;
    logic [1:0]  resultsrc_d;
    logic        stall_e, flush_e;
    logic [31:0] result_w;
    logic        regwrite_w;
    logic [4:0]  rd_w;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic        resultsrc0_e, pcsrc_e;
    logic [31:0] pctarget_e;
    logic        valid_m, regwrite_m, memwrite_m;
    logic [1:0]  resultsrc_m;
    logic [31:0] aluresult_m, writedata_m, pcplus4_m;
    logic [4:0]  rd_m;

    ex_stage #(.XLEN(32), .PC_RESET(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .valid_d(valid_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .immext_d(immext_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .alucontrol_d(alucontrol_d),
        .alusrc_d(alusrc_d), .regwrite_d(regwrite_d), .memwrite_d(memwrite_d),
        .branch_d(branch_d), .jump_d(jump_d), .resultsrc_d(resultsrc_d),
        .stall_e(stall_e), .flush_e(flush_e),
        .result_w(result_w), .regwrite_w(regwrite_w), .rd_w(rd_w),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .resultsrc0_e(resultsrc0_e),
        .pcsrc_e(pcsrc_e), .pctarget_e(pctarget_e),
        .valid_m(valid_m), .regwrite_m(regwrite_m), .memwrite_m(memwrite_m),
        .resultsrc_m(resultsrc_m), .aluresult_m(aluresult_m), .writedata_m(writedata_m),
        .pcplus4_m(pcplus4_m), .rd_m(rd_m)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    typedef struct packed {
        logic        v;
        logic        rw;
        logic        mw;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [31:0] wd;
        logic [31:0] p4;
    } exp_t;

    typedef struct packed {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] val;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wq[$];
    logic [31:0] arch[32];
    logic [31:0] rf[32];
    vec_t        vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Rules of each opcode written as plain arithmetic.
    function automatic logic [31:0] alu_ref(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] d;
        int          s;
        d = {a, a};
        s = int'(b[4:0]);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            ALU_SLL:  return a << s;
            ALU_SRL:  return a >> s;
            ALU_ANDN: return a & ~b;
            ALU_ORN:  return a | ~b;
            ALU_XNOR: return ~(a ^ b);
            ALU_MIN:  return (int'(a) < int'(b)) ? a : b;
            ALU_MAX:  return (int'(a) > int'(b)) ? a : b;
            ALU_MINU: return (a < b) ? a : b;
            ALU_MAXU: return (a > b) ? a : b;
            ALU_ROL:  return d[63-s -: 32];
            ALU_ROR:  return d[s +: 32];
            ALU_ABS:  return (int'(a) < 0) ? (32'd0 - a) : a;
            default:  return 32'd0;
        endcase
    endfunction

    task automatic clear_d();
        valid_d = 0; rd1_d = 0; rd2_d = 0; pc_d = 0; pcplus4_d = 0; immext_d = 0;
        rs1_d = 0; rs2_d = 0; rd_d = 0; alucontrol_d = 0; alusrc_d = 0;
        regwrite_d = 0; memwrite_d = 0; branch_d = 0; jump_d = 0; resultsrc_d = 0;
        stall_e = 0; flush_e = 0;
    endtask

    task automatic rand_d();
        valid_d = 1'($urandom_range(0, 1)); rd1_d = $urandom; rd2_d = $urandom;
        pc_d = $urandom; pcplus4_d = $urandom; immext_d = $urandom;
        rs1_d = 5'($urandom); rs2_d = 5'($urandom); rd_d = 5'($urandom);
        alucontrol_d = 5'($urandom_range(0, 17)); alusrc_d = 1'($urandom);
        regwrite_d = 1'($urandom); memwrite_d = 1'($urandom); branch_d = 1'($urandom);
        jump_d = 1'($urandom); resultsrc_d = 2'($urandom_range(0, 2));
        stall_e = 1'($urandom); flush_e = 1'($urandom);
        result_w = $urandom; regwrite_w = 1'($urandom); rd_w = 5'($urandom);
    endtask

    task automatic drive_alu(input alu_op_t op, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        valid_d = 1; regwrite_d = 1; alucontrol_d = op;
        rs1_d = rs1; rs2_d = rs2; rd_d = rd; rd1_d = a; rd2_d = b;
    endtask

    // One clock; afterwards the WB inputs carry what sat in EX/MEM before the edge.
    task automatic cycle();
        logic        v, rw;
        logic [4:0]  r;
        logic [31:0] res;
        v = valid_m; rw = regwrite_m; r = rd_m; res = aluresult_m;
        @(posedge clk);
        #1;
        regwrite_w = v & rw; rd_w = r; result_w = res;
    endtask

    task automatic drain();
        clear_d();
        repeat (3) cycle();
    endtask

    initial begin
        vecs[0]  = '{ALU_ADD,  32'd5,          32'd7,          32'd12};
        vecs[1]  = '{ALU_SUB,  32'd3,          32'd4,          32'hFFFF_FFFF};
        vecs[2]  = '{ALU_AND,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000};
        vecs[3]  = '{ALU_OR,   32'h0000_F0F0,  32'h0000_0F0F,  32'h0000_FFFF};
        vecs[4]  = '{ALU_XOR,  32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0};
        vecs[5]  = '{ALU_SLT,  32'hFFFF_FFFF,  32'd1,          32'd1};
        vecs[6]  = '{ALU_SLL,  32'd1,          32'd31,         32'h8000_0000};
        vecs[7]  = '{ALU_SRL,  32'h8000_0000,  32'd4,          32'h0800_0000};
        vecs[8]  = '{ALU_ANDN, 32'h0000_00FF,  32'h0000_000F,  32'h0000_00F0};
        vecs[9]  = '{ALU_ORN,  32'd0,          32'hFFFF_0000,  32'h0000_FFFF};
        vecs[10] = '{ALU_XNOR, 32'hFFFF_0000,  32'hFF00_FF00,  32'hFF00_00FF};
        vecs[11] = '{ALU_MIN,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFE};
        vecs[12] = '{ALU_MAX,  32'hFFFF_FFFE,  32'd3,          32'd3};
        vecs[13] = '{ALU_MINU, 32'hFFFF_FFFE,  32'd3,          32'd3};
        vecs[14] = '{ALU_MAXU, 32'd3,          32'hFFFF_FFFF,  32'hFFFF_FFFF};
        vecs[15] = '{ALU_ROL,  32'h8000_0001,  32'd1,          32'h0000_0003};
        vecs[16] = '{ALU_ROR,  32'h0000_0003,  32'd1,          32'h8000_0001};
        vecs[17] = '{ALU_ABS,  32'hFFFF_FFF6,  32'd0,          32'd10};
        vecs[18] = '{ALU_ROL,  32'h1234_5678,  32'd0,          32'h1234_5678};
        vecs[19] = '{ALU_ABS,  32'h8000_0000,  32'd0,          32'h8000_0000};

        // Reset held with random inputs: everything observable stays at zero.
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            rand_d();
            @(posedge clk);
            #1;
        end
        chk("rst rs1_e", 32'(rs1_e), 32'd0);
        chk("rst rs2_e", 32'(rs2_e), 32'd0);
        chk("rst rd_e", 32'(rd_e), 32'd0);
        chk("rst resultsrc0_e", 32'(resultsrc0_e), 32'd0);
        chk("rst pcsrc_e", 32'(pcsrc_e), 32'd0);
        chk("rst pctarget_e", pctarget_e, 32'd0);
        chk("rst valid_m", 32'(valid_m), 32'd0);
        chk("rst regwrite_m", 32'(regwrite_m), 32'd0);
        chk("rst memwrite_m", 32'(memwrite_m), 32'd0);
        chk("rst resultsrc_m", 32'(resultsrc_m), 32'd0);
        chk("rst aluresult_m", aluresult_m, 32'd0);
        chk("rst writedata_m", writedata_m, 32'd0);
        chk("rst pcplus4_m", pcplus4_m, 32'd0);
        chk("rst rd_m", 32'(rd_m), 32'd0);

        reset = 1;
        clear_d();
        result_w = 0; regwrite_w = 0; rd_w = 0;
        drive_alu(ALU_ADD, 5'd0, 5'd0, 5'd3, 32'd5, 32'd7);
        cycle();
        clear_d();
        cycle();
        chk("first aluresult_m", aluresult_m, 32'd12);
        chk("first rd_m", 32'(rd_m), 32'd3);
        chk("first regwrite_m", 32'(regwrite_m), 32'd1);
        chk("first valid_m", 32'(valid_m), 32'd1);
        drain();

        // Opcode table, one instruction then one bubble each.
        for (int i = 0; i < 20; i++) begin
            clear_d();
            drive_alu(vecs[i].op, 5'd0, 5'd0, 5'd10, vecs[i].a, vecs[i].b);
            cycle();
            clear_d();
            cycle();
            chk($sformatf("vec%0d %s", i, vecs[i].op.name()), aluresult_m, vecs[i].y);
        end
        drain();

        // MEM forward into rs1; then the same with an x0 producer.
        for (int k = 0; k < 2; k++) begin
            clear_d();
            drive_alu(ALU_ADD, 5'd6, 5'd7, (k == 0) ? 5'd1 : 5'd0, 32'd3, 32'd4);
            cycle();
            clear_d();
            drive_alu(ALU_SUB, 5'd1, 5'd0, 5'd2, 32'd0, 32'd0);
            alusrc_d = 1; immext_d = 32'd1;
            cycle();
            clear_d();
            cycle();
            chk(k == 0 ? "mem fwd" : "x0 no fwd", aluresult_m, (k == 0) ? 32'd6 : 32'hFFFF_FFFF);
            drain();
        end

        // MEM and WB both hold x5: MEM wins.
        drive_alu(ALU_ADD, 5'd0, 5'd0, 5'd5, 32'd100, 32'd0);
        cycle();
        drive_alu(ALU_ADD, 5'd0, 5'd0, 5'd5, 32'd9, 32'd0);
        cycle();
        drive_alu(ALU_XOR, 5'd5, 5'd0, 5'd6, 32'h0000_DEAD, 32'd0);
        cycle();
        clear_d();
        cycle();
        chk("mem over wb", aluresult_m, 32'd9);
        drain();

        // WB-only forward into rs2 (store data path).
        drive_alu(ALU_ADD, 5'd0, 5'd0, 5'd8, 32'd100, 32'd0);
        cycle();
        clear_d();
        cycle();
        drive_alu(ALU_XOR, 5'd0, 5'd8, 5'd6, 32'd0, 32'h0000_DEAD);
        cycle();
        clear_d();
        cycle();
        chk("wb fwd result", aluresult_m, 32'd100);
        chk("wb fwd writedata", writedata_m, 32'd100);
        drain();

        // BEQ taken for one cycle, not taken, stalled, and a wrapping JAL.
        valid_d = 1; branch_d = 1; alucontrol_d = ALU_SUB;
        pc_d = 32'h100; immext_d = 32'h20; rd1_d = 32'h55; rd2_d = 32'h55;
        cycle();
        clear_d();
        #1;
        chk("beq taken pcsrc", 32'(pcsrc_e), 32'd1);
        chk("beq pctarget", pctarget_e, 32'h120);
        flush_e = 1;
        cycle();
        flush_e = 0;
        #1;
        chk("beq one cycle", 32'(pcsrc_e), 32'd0);
        valid_d = 1; branch_d = 1; alucontrol_d = ALU_SUB;
        pc_d = 32'h100; immext_d = 32'h20; rd1_d = 32'h55; rd2_d = 32'h56;
        cycle();
        clear_d();
        #1;
        chk("beq not taken", 32'(pcsrc_e), 32'd0);
        valid_d = 1; branch_d = 1; alucontrol_d = ALU_SUB; rd1_d = 32'h7; rd2_d = 32'h7;
        cycle();
        clear_d();
        stall_e = 1;
        #1;
        chk("beq stalled", 32'(pcsrc_e), 32'd0);
        stall_e = 0;
        cycle();
        valid_d = 1; jump_d = 1; pc_d = 32'hFFFF_FFF0; immext_d = 32'h20;
        cycle();
        clear_d();
        #1;
        chk("jal pcsrc", 32'(pcsrc_e), 32'd1);
        chk("jal pctarget wrap", pctarget_e, 32'h10);
        drain();

        // Two-cycle stall on MAXU: two bubbles, then exactly one issue.
        drive_alu(ALU_MAXU, 5'd0, 5'd0, 5'd9, 32'd3, 32'hFFFF_FFFF);
        cycle();
        clear_d();
        drive_alu(ALU_ADD, 5'd0, 5'd0, 5'd11, 32'd1, 32'd1);
        stall_e = 1;
        cycle();
        chk("stall bubble 1", 32'(valid_m), 32'd0);
        cycle();
        chk("stall bubble 2", 32'(valid_m), 32'd0);
        stall_e = 0;
        cycle();
        chk("stall release valid", 32'(valid_m), 32'd1);
        chk("stall release result", aluresult_m, 32'hFFFF_FFFF);
        chk("stall release rd", 32'(rd_m), 32'd9);
        clear_d();
        cycle();
        chk("after stall result", aluresult_m, 32'd2);
        chk("after stall rd", 32'(rd_m), 32'd11);
        drain();

        // Flush and stall together: flush wins.
        drive_alu(ALU_ADD, 5'd0, 5'd0, 5'd12, 32'd1, 32'd2);
        cycle();
        clear_d();
        flush_e = 1; stall_e = 1;
        cycle();
        flush_e = 0; stall_e = 0;
        chk("flush+stall rd_e", 32'(rd_e), 32'd0);
        cycle();
        chk("flush+stall valid_m", 32'(valid_m), 32'd0);
        drain();

        // ROL with immediate, then reset mid-stream.
        drive_alu(ALU_ROL, 5'd0, 5'd0, 5'd4, 32'h8000_0001, 32'h77);
        alusrc_d = 1; immext_d = 32'd1;
        cycle();
        clear_d();
        drive_alu(ALU_ADD, 5'd0, 5'd0, 5'd13, 32'd1, 32'd1);
        cycle();
        clear_d();
        chk("rol result", aluresult_m, 32'h0000_0003);
        chk("rol writedata", writedata_m, 32'h77);
        chk("rol valid_m", 32'(valid_m), 32'd1);
        chk("pre-reset rd_e", 32'(rd_e), 32'd13);
        reset = 0;
        #1;
        chk("mid reset valid_m", 32'(valid_m), 32'd0);
        chk("mid reset aluresult_m", aluresult_m, 32'd0);
        chk("mid reset rd_e", 32'(rd_e), 32'd0);
        @(posedge clk);
        #1;
        reset = 1;
        regwrite_w = 0; rd_w = 0; result_w = 0;
        drain();

        // Random instruction stream against an architectural register model.
        // rf is what decode reads: only writes from 3+ slots back are visible.
        arch[0] = 0;
        for (int r = 1; r < 32; r++) arch[r] = $urandom;
        rf = arch;
        for (int k = 0; k < 302; k++) begin
            wr_t         w;
            exp_t        e;
            alu_op_t     op;
            logic [4:0]  s1, s2, rdx;
            logic [31:0] imm, p4, bval, y;
            logic        asrc, rw, mw;
            if (wq.size() == 3) begin
                w = wq.pop_front();
                if (w.v && w.rd != 5'd0) rf[w.rd] = w.val;
            end
            clear_d();
            e = '0;
            w = '0;
            if (k < 300 && $urandom_range(0, 9) != 0) begin
                op = alu_op_t'($urandom_range(0, 17));
                s1 = 5'($urandom_range(0, 7)); s2 = 5'($urandom_range(0, 7));
                rdx = 5'($urandom_range(0, 7));
                asrc = 1'($urandom_range(0, 1)); rw = ($urandom_range(0, 3) != 0);
                mw = 1'($urandom_range(0, 1)); imm = $urandom; p4 = $urandom;
                bval = arch[s2];
                y = alu_ref(op, arch[s1], asrc ? imm : bval);
                valid_d = 1; alucontrol_d = op; rs1_d = s1; rs2_d = s2; rd_d = rdx;
                rd1_d = rf[s1]; rd2_d = rf[s2]; alusrc_d = asrc; immext_d = imm;
                regwrite_d = rw; memwrite_d = mw; pcplus4_d = p4; pc_d = $urandom;
                e = '{v: 1'b1, rw: rw, mw: mw, rd: rdx, res: y, wd: bval, p4: p4};
                w = '{v: rw, rd: rdx, val: y};
                if (rw && rdx != 5'd0) arch[rdx] = y;
            end
            wq.push_back(w);
            exp_q.push_back(e);
            cycle();
            if (exp_q.size() == 2) begin
                e = exp_q.pop_front();
                chk($sformatf("rnd%0d valid_m", k), 32'(valid_m), 32'(e.v));
                chk($sformatf("rnd%0d regwrite_m", k), 32'(regwrite_m), 32'(e.rw));
                chk($sformatf("rnd%0d memwrite_m", k), 32'(memwrite_m), 32'(e.mw));
                if (e.v) begin
                    chk($sformatf("rnd%0d rd_m", k), 32'(rd_m), 32'(e.rd));
                    chk($sformatf("rnd%0d aluresult_m", k), aluresult_m, e.res);
                    chk($sformatf("rnd%0d writedata_m", k), writedata_m, e.wd);
                    chk($sformatf("rnd%0d pcplus4_m", k), pcplus4_m, e.p4);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
